led_bank_ctrl: RTL and testbench

Parametrised, register-mapped LED output controller; successor to the single 16-bit LED register peripheral.
- Driven by the same write bus as the ROM sequencer (wr_en / data_address / write_data), plus a read-back port.
- Adds per-LED blink masking with a programmable blink period, global enable/invert control, and out-of-range address flagging.
- Every write takes effect on the LED outputs exactly one clock after the write strobe; no multi-cycle write path.

---
 rtl/led_periph_pkg.sv | 23 ++
 rtl/led_blink_timer.sv | 32 +++
 rtl/led_bank_ctrl.sv | 135 +++++++++++++
 tb/tb_led_bank_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_periph_pkg.sv
// Shared constants for the LED bank controller: register offsets relative to
// BASE_ADDR (as functions of the byte-bank count) and CTRL bit layout.
package led_periph_pkg;

  localparam int unsigned OFF_VALUE = 0;

  function automatic int unsigned OFF_MASK(input int unsigned nb);
    return nb;
  endfunction

  function automatic int unsigned OFF_PERIOD(input int unsigned nb);
    return 2 * nb;
  endfunction

  function automatic int unsigned OFF_CTRL(input int unsigned nb);
    return 2 * nb + 1;
  endfunction

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;
  localparam logic [7:0]  CTRL_RST = 8'h01;

endpackage

// File: rtl/led_blink_timer.sv
// Blink prescaler: blink_phase holds each level for PERIOD+1 cycles; a PERIOD
// write restarts the phase at 1, and PERIOD = 0 parks the phase at 1.
module led_blink_timer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] period,
  input  logic              period_wr,
  output logic              blink_phase
);

  logic [DATA_W-1:0] r_count;
  logic              r_phase;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || period_wr || period == '0) begin
      r_count <= '0;
      r_phase <= 1'b1;
    end else if (r_count == period) begin
      r_count <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign blink_phase = r_phase;

endmodule

// File: rtl/led_bank_ctrl.sv
// Register-mapped LED bank: VALUE/MASK byte banks, blink PERIOD and CTRL
// (EN/INV), registered read-back with out-of-range flagging.
module led_bank_ctrl
  import led_periph_pkg::*;
#(
  parameter int unsigned       NUM_LEDS  = 16,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   read_data,
  output logic                rd_valid,
  output logic                addr_err,
  output logic [NUM_LEDS-1:0] led,
  output logic                blink_phase
);

  localparam int unsigned NB = NUM_LEDS / DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + OFF_CTRL(NB));
  localparam logic [ADDR_W-1:0] A_PERIOD  = ADDR_W'(OFF_PERIOD(NB));
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(OFF_CTRL(NB));

  logic [DATA_W-1:0]   r_value [NB];
  logic [DATA_W-1:0]   r_mask  [NB];
  logic [DATA_W-1:0]   r_period;
  logic                r_en;
  logic                r_inv;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_rd_valid;
  logic                r_addr_err;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_in_range;
  logic [ADDR_W-1:0]   w_offset;
  logic                w_wr;
  logic                w_period_wr;
  logic                w_blink_phase;
  logic [DATA_W-1:0]   w_rd_data;
  logic [NUM_LEDS-1:0] w_value_flat;
  logic [NUM_LEDS-1:0] w_mask_flat;
  logic [NUM_LEDS-1:0] w_raw;

  assign w_in_range  = (data_address >= BASE_ADDR) && (data_address <= LAST_ADDR);
  assign w_offset    = data_address - BASE_ADDR;
  assign w_wr        = wr_en && w_in_range;
  assign w_period_wr = w_wr && (w_offset == A_PERIOD);

  led_blink_timer #(.DATA_W(DATA_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .period     (r_period),
    .period_wr  (w_period_wr),
    .blink_phase(w_blink_phase)
  );

  // NOTE: the register banks are a handful of flops, so they are reset
  // explicitly; a true RAM would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        r_value[k] <= '0;
        r_mask[k]  <= '0;
      end
      r_period <= '0;
      r_en     <= CTRL_RST[CTRL_EN];
      r_inv    <= CTRL_RST[CTRL_INV];
    end else if (w_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (w_offset == ADDR_W'(OFF_VALUE + k)) r_value[k] <= write_data;
        if (w_offset == ADDR_W'(OFF_MASK(NB) + k)) r_mask[k] <= write_data;
      end
      if (w_offset == A_PERIOD) r_period <= write_data;
      if (w_offset == A_CTRL) begin
        r_en  <= write_data[CTRL_EN];
        r_inv <= write_data[CTRL_INV];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (w_offset == ADDR_W'(OFF_VALUE + k)) w_rd_data = r_value[k];
        if (w_offset == ADDR_W'(OFF_MASK(NB) + k)) w_rd_data = r_mask[k];
      end
      if (w_offset == A_PERIOD) w_rd_data = r_period;
      if (w_offset == A_CTRL) begin
        w_rd_data[CTRL_EN]  = r_en;
        w_rd_data[CTRL_INV] = r_inv;
      end
    end
  end

  always_comb begin
    w_value_flat = '0;
    w_mask_flat  = '0;
    for (int k = 0; k < NB; k++) begin
      w_value_flat[k*DATA_W +: DATA_W] = r_value[k];
      w_mask_flat[k*DATA_W +: DATA_W]  = r_mask[k];
    end
  end

  assign w_raw = w_value_flat & (~w_mask_flat | {NUM_LEDS{w_blink_phase}});

  // Reads sample pre-edge register contents, so a colliding write reads old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
      r_rd_valid  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_led       <= '0;
    end else begin
      if (rd_en) r_read_data <= w_rd_data;
      r_rd_valid <= rd_en;
      r_addr_err <= (wr_en || rd_en) && !w_in_range;
      r_led      <= r_en ? (w_raw ^ {NUM_LEDS{r_inv}}) : '0;
    end
  end

  assign read_data   = r_read_data;
  assign rd_valid    = r_rd_valid;
  assign addr_err    = r_addr_err;
  assign led         = r_led;
  assign blink_phase = w_blink_phase;

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Directed plus randomized bench for led_bank_ctrl (16 LEDs, map 0x10-0x15),
// checked against a register-level reference model.
module tb_led_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  data_address = '0;
  logic [7:0]  write_data = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  read_data;
  logic        rd_valid;
  logic        addr_err;
  logic [15:0] led;
  logic        blink_phase;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: register contents plus cycles since the blink
  // timer was last restarted.
  logic [15:0] m_value, m_mask;
  logic [7:0]  m_period;
  logic [1:0]  m_ctrl;
  int          m_elapsed;

  led_bank_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_address(data_address),
    .write_data  (write_data),
    .rd_en       (rd_en),
    .read_data   (read_data),
    .rd_valid    (rd_valid),
    .addr_err    (addr_err),
    .led         (led),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_phase();
    if (m_period == 0) return 1'b1;
    return ((m_elapsed / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h10:   return m_value[7:0];
      8'h11:   return m_value[15:8];
      8'h12:   return m_mask[7:0];
      8'h13:   return m_mask[15:8];
      8'h14:   return m_period;
      8'h15:   return {6'b0, m_ctrl};
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge: drive inputs, advance the model, compare all outputs.
  task automatic step(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic rd);
    logic [15:0] exp_led;
    logic [7:0]  exp_rd;
    logic        in_range;
    rst = r; wr_en = w; data_address = a; write_data = d; rd_en = rd;
    in_range = (a >= 8'h10) && (a <= 8'h15);
    exp_led  = m_ctrl[0] ? ((m_value & (~m_mask | {16{model_phase()}})) ^ {16{m_ctrl[1]}}) : 16'h0;
    exp_rd   = model_read(a);
    @(posedge clk);
    #1;
    if (r) begin
      m_value = '0; m_mask = '0; m_period = '0; m_ctrl = 2'b01; m_elapsed = 0;
      check("rst_led", led, 16'h0);
      check("rst_rd_valid", {15'b0, rd_valid}, 16'h0);
      check("rst_read_data", {8'b0, read_data}, 16'h0);
      check("rst_addr_err", {15'b0, addr_err}, 16'h0);
    end else begin
      m_elapsed++;
      if (w && in_range) begin
        case (a)
          8'h10: m_value[7:0]  = d;
          8'h11: m_value[15:8] = d;
          8'h12: m_mask[7:0]   = d;
          8'h13: m_mask[15:8]  = d;
          8'h14: begin m_period = d; m_elapsed = 0; end
          default: m_ctrl = d[1:0];
        endcase
      end
      check("led", led, exp_led);
      check("rd_valid", {15'b0, rd_valid}, {15'b0, rd});
      check("addr_err", {15'b0, addr_err}, {15'b0, (w || rd) && !in_range});
      if (rd) check("read_data", {8'b0, read_data}, {8'b0, exp_rd});
    end
    check("blink_phase", {15'b0, blink_phase}, {15'b0, model_phase()});
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    m_value = '0; m_mask = '0; m_period = '0; m_ctrl = 2'b01; m_elapsed = 0;

    // Reset and write latency
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h15, 8'h00, 1'b1);
    check("ctrl_reset_read", {8'b0, read_data}, 16'h0001);
    step(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    check("lat_first", led, 16'h0000);
    step(1'b0, 1'b1, 8'h11, 8'h3C, 1'b0);
    check("lat_second", led, 16'h00A5);
    step(1'b0, 1'b0, 8'h11, 8'h00, 1'b1);
    check("lat_both", led, 16'h3CA5);
    check("readback", {8'b0, read_data}, 16'h003C);
    idle(1);
    check("rd_valid_drop", {15'b0, rd_valid}, 16'h0);

    // Read/write collision
    step(1'b0, 1'b1, 8'h11, 8'h77, 1'b1);
    check("collide_old", {8'b0, read_data}, 16'h003C);
    step(1'b0, 1'b0, 8'h11, 8'h00, 1'b1);
    check("collide_new", {8'b0, read_data}, 16'h0077);

    // Control
    step(1'b0, 1'b1, 8'h11, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h15, 8'h03, 1'b0);
    idle(1);
    check("ctrl_inv", led, 16'hFF5A);
    step(1'b0, 1'b1, 8'h15, 8'h02, 1'b0);
    idle(1);
    check("ctrl_off", led, 16'h0000);
    step(1'b0, 1'b1, 8'h15, 8'h01, 1'b0);
    idle(1);
    check("ctrl_on", led, 16'h00A5);

    // Out of range
    step(1'b0, 1'b1, 8'h0F, 8'hFF, 1'b0);
    check("oor_low_err", {15'b0, addr_err}, 16'h1);
    idle(1);
    check("oor_err_pulse", {15'b0, addr_err}, 16'h0);
    step(1'b0, 1'b1, 8'h16, 8'hFF, 1'b0);
    check("oor_high_err", {15'b0, addr_err}, 16'h1);
    step(1'b0, 1'b0, 8'h20, 8'h00, 1'b1);
    check("oor_read", {7'b0, read_data, rd_valid}, 16'h0001);
    idle(1);
    check("oor_led", led, 16'h00A5);

    // Blink
    step(1'b0, 1'b1, 8'h10, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h11, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h12, 8'h0F, 1'b0);
    step(1'b0, 1'b1, 8'h14, 8'h03, 1'b0);
    idle(5);
    check("blink_low", {15'b0, blink_phase}, 16'h0);
    check("blink_led_low", led, 16'hFFF0);
    step(1'b0, 1'b1, 8'h14, 8'h03, 1'b0);
    check("period_rewrite", {15'b0, blink_phase}, 16'h1);
    idle(12);

    // Reset mid-blink
    step(1'b0, 1'b1, 8'h14, 8'h05, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("midrst_led", led, 16'h0000);
    check("midrst_phase", {15'b0, blink_phase}, 16'h1);
    step(1'b0, 1'b0, 8'h14, 8'h00, 1'b1);
    check("midrst_period", {8'b0, read_data}, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(8'h0E, 8'h17));
      d = 8'($urandom);
      if (a == 8'h14) d = 8'($urandom_range(0, 4));
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), a, d,
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
